// File: rtl/width_down_mux_pkg.sv
// rtl/width_down_mux_pkg.sv - lane-count macro, default idle symbol and lane-index width helper for width_down_mux
`ifndef WDM_LANES
`define WDM_LANES(i,o) ((i)/(o))
`endif

package width_down_mux_pkg;

  // Idle symbol shown on data_out when idle fill is built in
  localparam logic [7:0] WDM_IDLE_SYM_DEFAULT = 8'hBC;

  // Width of a lane index; never narrower than one bit
  function automatic int wdm_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/wdm_lane_select.sv
// rtl/wdm_lane_select.sv - combinational extraction of lane n from a parallel word
module wdm_lane_select
  import width_down_mux_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 1,
  parameter int LANES     = `WDM_LANES(IN_W, OUT_W),
  parameter int IDX_W     = wdm_idx_w(LANES)
) (
  input  logic [IN_W-1:0]  i_word,
  input  logic [IDX_W-1:0] i_idx,
  output logic [OUT_W-1:0] o_lane
);

  logic [OUT_W-1:0] w_lanes [LANES];

  // Lane 0 is the top slice when MSB_FIRST, otherwise the bottom slice
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    if (MSB_FIRST != 0) begin : g_msb
      assign w_lanes[g] = i_word[IN_W-1-g*OUT_W -: OUT_W];
    end else begin : g_lsb
      assign w_lanes[g] = i_word[g*OUT_W +: OUT_W];
    end
  end

  assign o_lane = w_lanes[i_idx];

endmodule

// File: rtl/width_down_mux.sv
// rtl/width_down_mux.sv - IN_W:OUT_W word-to-lane mux with current+pending buffer; optional WDM_IDLE_FILL_EN
module width_down_mux
  import width_down_mux_pkg::*;
#(
  parameter int               IN_W      = 32,
  parameter int               OUT_W     = 8,
  parameter int               MSB_FIRST = 1,
  parameter logic [OUT_W-1:0] IDLE_SYM  = OUT_W'(WDM_IDLE_SYM_DEFAULT)
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic [IN_W-1:0]  data_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_out
);

  localparam int               LANES    = `WDM_LANES(IN_W, OUT_W);
  localparam int               IDX_W    = wdm_idx_w(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IN_W-1:0]  r_cur_word;
  logic             r_cur_valid;
  logic [IDX_W-1:0] r_lane_cnt;
  logic [IN_W-1:0]  r_pend_word;
  logic             r_pend_valid;

  logic             w_ready_in;
  logic             w_accept;
  logic             w_lane_xfer;
  logic             w_last_xfer;
  logic [OUT_W-1:0] w_sel_lane;

  // ready_in depends only on registered state and reset, never on valid_in/ready_out
  assign w_ready_in  = reset_L & ~r_pend_valid;
  assign w_accept    = valid_in & w_ready_in;
  assign w_lane_xfer = r_cur_valid & ready_out;
  assign w_last_xfer = w_lane_xfer & (r_lane_cnt == LAST_IDX);

  wdm_lane_select #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST),
    .LANES     (LANES),
    .IDX_W     (IDX_W)
  ) u_lane_select (
    .i_word (r_cur_word),
    .i_idx  (r_lane_cnt),
    .o_lane (w_sel_lane)
  );

  // Lane counter advances on each lane transfer and wraps after the last lane
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_lane_cnt <= '0;
    end else if (w_lane_xfer) begin
      r_lane_cnt <= w_last_xfer ? '0 : r_lane_cnt + 1'b1;
    end
  end

  // Current/pending buffer: pending refills current first, else a same-edge accept bypasses into current
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_cur_word   <= '0;
      r_cur_valid  <= 1'b0;
      r_pend_word  <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_last_xfer) begin
      if (r_pend_valid) begin
        r_cur_word   <= r_pend_word;
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_cur_word   <= data_in;
      end else begin
        r_cur_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_cur_valid) begin
        r_cur_word   <= data_in;
        r_cur_valid  <= 1'b1;
      end else begin
        r_pend_word  <= data_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign ready_in  = w_ready_in;
  assign valid_out = r_cur_valid;

`ifdef WDM_IDLE_FILL_EN
  assign data_out = r_cur_valid ? w_sel_lane : IDLE_SYM;
`else
  logic [OUT_W-1:0] r_hold_lane;
  logic [OUT_W-1:0] w_unused_idle_sym;

  assign w_unused_idle_sym = IDLE_SYM;

  // Remember the lane last handed downstream so idle cycles keep showing it
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_hold_lane <= '0;
    end else if (w_lane_xfer) begin
      r_hold_lane <= w_sel_lane;
    end
  end

  assign data_out = r_cur_valid ? w_sel_lane : r_hold_lane;
`endif

endmodule

// File: tb/tb_width_down_mux.sv
// tb/tb_width_down_mux.sv - randomized and directed bench for width_down_mux against a queue model
module tb_width_down_mux;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int R     = IN_W / OUT_W;

  logic             clk_4f = 1'b0;
  logic             reset_L = 1'b0;
  logic [IN_W-1:0]  data_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_out = 1'b0;

  logic             m_ready_in, m_valid_out, l_ready_in, l_valid_out;
  logic [OUT_W-1:0] m_data_out, l_data_out;

  always #5 clk_4f = ~clk_4f;

  width_down_mux #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1)) u_dut_msb (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_in(m_ready_in), .data_out(m_data_out), .valid_out(m_valid_out), .ready_out(ready_out)
  );

  width_down_mux #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(0)) u_dut_lsb (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_in(l_ready_in), .data_out(l_data_out), .valid_out(l_valid_out), .ready_out(ready_out)
  );

  // Model: words waiting or in progress, lanes already sent of the head word, last lane sent
  logic [IN_W-1:0]  mq[$];
  int               consumed = 0;
  logic [OUT_W-1:0] last_m = '0;
  logic [OUT_W-1:0] last_l = '0;

  int checks = 0;
  int errors = 0;

  function automatic logic [OUT_W-1:0] lane_of(input logic [IN_W-1:0] w, input int n, input bit msb);
    int sh;
    sh = msb ? (R - 1 - n) * OUT_W : n * OUT_W;
    return OUT_W'(w >> sh);
  endfunction

  function automatic logic [OUT_W-1:0] idle_val(input logic [OUT_W-1:0] last);
`ifdef WDM_IDLE_FILL_EN
    return 8'hBC;
`else
    return last;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the model on every falling edge
  always @(negedge clk_4f) begin
    logic ev;
    logic er;
    ev = (mq.size() > 0);
    er = reset_L && (mq.size() < 2);
    chk("ready_in_msb", 32'(m_ready_in), 32'(er));
    chk("ready_in_lsb", 32'(l_ready_in), 32'(er));
    chk("valid_out_msb", 32'(m_valid_out), 32'(ev));
    chk("valid_out_lsb", 32'(l_valid_out), 32'(ev));
    chk("data_out_msb", 32'(m_data_out), 32'(ev ? lane_of(mq[0], consumed, 1'b1) : idle_val(last_m)));
    chk("data_out_lsb", 32'(l_data_out), 32'(ev ? lane_of(mq[0], consumed, 1'b0) : idle_val(last_l)));
  end

  task automatic model_edge();
    bit acc;
    if (!reset_L) return;
    acc = valid_in && (mq.size() < 2);
    if (mq.size() > 0 && ready_out) begin
      last_m = lane_of(mq[0], consumed, 1'b1);
      last_l = lane_of(mq[0], consumed, 1'b0);
      consumed++;
      if (consumed == R) begin
        void'(mq.pop_front());
        consumed = 0;
      end
    end
    if (acc) mq.push_back(data_in);
  endtask

  task automatic tick(input logic v, input logic [IN_W-1:0] d, input logic ro);
    @(negedge clk_4f);
    #1;
    valid_in  = v;
    data_in   = d;
    ready_out = ro;
    @(posedge clk_4f);
    model_edge();
  endtask

  task automatic assert_reset();
    @(negedge clk_4f);
    #1;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    mq.delete();
    consumed = 0;
    last_m   = '0;
    last_l   = '0;
    #1;
    chk("rst_valid_now", 32'(m_valid_out), 32'h0);
    chk("rst_ready_now", 32'(m_ready_in), 32'h0);
    chk("rst_data_now", 32'(m_data_out), 32'(idle_val(8'h00)));
  endtask

  task automatic release_reset();
    @(negedge clk_4f);
    #1;
    reset_L = 1'b1;
    #1;
    chk("rel_ready_now", 32'(m_ready_in), 32'h1);
    chk("rel_valid_now", 32'(m_valid_out), 32'h0);
  endtask

  // Literal expectation a little after the edge just taken
  task automatic lit(input string name, input logic [7:0] m_exp, input logic [7:0] l_exp, input logic v_exp);
    #2;
    chk({name, "_v"}, 32'(m_valid_out), 32'(v_exp));
    if (v_exp) begin
      chk({name, "_m"}, 32'(m_data_out), 32'(m_exp));
      chk({name, "_l"}, 32'(l_data_out), 32'(l_exp));
    end
  endtask

  initial begin
    logic [7:0] seq3 [8];
    logic [7:0] tmp [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    seq3 = tmp;

    // 1: reset state and release
    #2;
    chk("t1_valid", 32'(m_valid_out), 32'h0);
    chk("t1_ready", 32'(m_ready_in), 32'h0);
    chk("t1_data", 32'(m_data_out), 32'(idle_val(8'h00)));
    tick(1'b0, '0, 1'b1);
    release_reset();

    // 2: single word
    tick(1'b1, 32'hAABBCCDD, 1'b1); lit("t2_0", 8'hAA, 8'hDD, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t2_1", 8'hBB, 8'hCC, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t2_2", 8'hCC, 8'hBB, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t2_3", 8'hDD, 8'hAA, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t2_idle", 8'h00, 8'h00, 1'b0);

    // 3: back-to-back words, second waits in pend
    tick(1'b1, 32'hAABBCCDD, 1'b1); lit("t3_0", 8'hAA, 8'hDD, 1'b1);
    tick(1'b1, 32'h11223344, 1'b1); lit("t3_1", 8'hBB, 8'hCC, 1'b1);
    chk("t3_ready_pend", 32'(m_ready_in), 32'h0);
    for (int i = 2; i < 8; i++) begin
      tick(1'b0, '0, 1'b1);
      #2;
      chk("t3_lane", 32'(m_data_out), 32'(seq3[i]));
      chk("t3_lane_v", 32'(m_valid_out), 32'h1);
    end
    tick(1'b0, '0, 1'b1); lit("t3_idle", 8'h00, 8'h00, 1'b0);

    // 4: backpressure while BB is shown
    tick(1'b1, 32'hAABBCCDD, 1'b1); lit("t4_0", 8'hAA, 8'hDD, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t4_1", 8'hBB, 8'hCC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b0);         lit("t4_hold", 8'hBB, 8'hCC, 1'b1);
    end
    tick(1'b0, '0, 1'b1);           lit("t4_2", 8'hCC, 8'hBB, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t4_3", 8'hDD, 8'hAA, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t4_idle", 8'h00, 8'h00, 1'b0);

    // 5: reset mid-word, then a fresh word shows only its own lanes
    tick(1'b1, 32'hAABBCCDD, 1'b1); lit("t5_0", 8'hAA, 8'hDD, 1'b1);
    tick(1'b0, '0, 1'b1);           lit("t5_1", 8'hBB, 8'hCC, 1'b1);
    assert_reset();
    tick(1'b0, '0, 1'b1);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, 32'hFFFFFFFF, 1'b1); lit("t5_ff", 8'hFF, 8'hFF, 1'b1);
    end
    tick(1'b0, '0, 1'b1);           lit("t5_idle", 8'h00, 8'h00, 1'b0);

    // Random traffic with occasional reset, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        tick(1'b0, '0, 1'b0);
        release_reset();
      end else begin
        tick(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 9) < 7));
      end
    end

    tick(1'b0, '0, 1'b1);
    @(negedge clk_4f);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
